// File: rtl/regfile_fwd_if.sv
// Bus bundle for regfile_fwd: WB write port, EX/MEM forwarding taps, two read ports and the write counter.
interface regfile_fwd_if;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic        ex_wreg;
  logic [4:0]  ex_wd;
  logic [31:0] ex_wdata;
  logic        mem_wreg;
  logic [4:0]  mem_wd;
  logic [31:0] mem_wdata;
  logic        re1;
  logic [4:0]  raddr1;
  logic [31:0] rdata1;
  logic        re2;
  logic [4:0]  raddr2;
  logic [31:0] rdata2;
  logic [15:0] wr_count;

  modport master (
    output we, waddr, wdata, ex_wreg, ex_wd, ex_wdata, mem_wreg, mem_wd, mem_wdata,
    output re1, raddr1, re2, raddr2,
    input  rdata1, rdata2, wr_count
  );

  modport slave (
    input  we, waddr, wdata, ex_wreg, ex_wd, ex_wdata, mem_wreg, mem_wd, mem_wdata,
    input  re1, raddr1, re2, raddr2,
    output rdata1, rdata2, wr_count
  );
endinterface

// File: rtl/regfile_fwd.sv
// MIPS GPR file with EX/MEM/WB operand forwarding folded into both combinational read ports.
module regfile_fwd #(
  parameter int REG_NUM        = 32,
  parameter bit ZERO_HARDWIRED = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  regfile_fwd_if.slave  bus
);

  logic [31:0]      regs_q [REG_NUM];
  logic [15:0]      wr_count_q;
  logic [15:0]      wr_count_d;
  logic             wr_ok_s;
  logic [1:0]       ren_s;
  logic [1:0][4:0]  ra_s;
  logic [1:0][31:0] rd_s;

  // Architectural write qualification and counter next-state.
  always_comb begin
    wr_ok_s    = 1'b0;
    wr_count_d = wr_count_q;
    if (bus.we && !(ZERO_HARDWIRED && (bus.waddr == 5'd0)) && (int'(bus.waddr) < REG_NUM)) begin
      wr_ok_s    = 1'b1;
      wr_count_d = wr_count_q + 16'd1;
    end else begin
      wr_ok_s    = 1'b0;
      wr_count_d = wr_count_q;
    end
  end

  // Register array and commit counter; reset wipes all architectural state.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < REG_NUM; i++) begin
        regs_q[i] <= 32'h0000_0000;
      end
      wr_count_q <= 16'h0000;
    end else begin
      if (wr_ok_s) begin
        regs_q[bus.waddr] <= bus.wdata;
      end
      wr_count_q <= wr_count_d;
    end
  end

  // Read ports: youngest producer wins (EX, MEM, WB, then array); r0 never forwards.
  always_comb begin
    ren_s = {bus.re2, bus.re1};
    ra_s  = {bus.raddr2, bus.raddr1};
    rd_s  = '0;
    for (int p = 0; p < 2; p++) begin
      if (rst || !ren_s[p] || (ZERO_HARDWIRED && (ra_s[p] == 5'd0))) begin
        rd_s[p] = 32'h0000_0000;
      end else if (bus.ex_wreg && (bus.ex_wd == ra_s[p])) begin
        rd_s[p] = bus.ex_wdata;
      end else if (bus.mem_wreg && (bus.mem_wd == ra_s[p])) begin
        rd_s[p] = bus.mem_wdata;
      end else if (bus.we && (bus.waddr == ra_s[p])) begin
        rd_s[p] = bus.wdata;
      end else if (int'(ra_s[p]) < REG_NUM) begin
        rd_s[p] = regs_q[ra_s[p]];
      end else begin
        rd_s[p] = 32'h0000_0000;
      end
    end
  end

  assign bus.rdata1   = rd_s[0];
  assign bus.rdata2   = rd_s[1];
  assign bus.wr_count = wr_count_q;

endmodule

// File: tb/tb_regfile_fwd.sv
// Table-driven bench for regfile_fwd with an expected-value queue and a counter-wrap sequence.
module tb_regfile_fwd;
  logic clk;
  logic rst;

  regfile_fwd_if bus ();

  regfile_fwd #(.REG_NUM(32), .ZERO_HARDWIRED(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  typedef struct {
    logic        tick;
    logic        rst;
    logic        we;   logic [4:0] wa;   logic [31:0] wd;
    logic        exw;  logic [4:0] exd;  logic [31:0] exv;
    logic        memw; logic [4:0] memd; logic [31:0] memv;
    logic        re1;  logic [4:0] ra1;
    logic        re2;  logic [4:0] ra2;
    logic [31:0] e1;
    logic [31:0] e2;
    logic [15:0] ecnt;
  } vec_t;

  typedef struct {
    string       name;
    logic [31:0] r1;
    logic [31:0] r2;
    logic [15:0] cnt;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic drive(input vec_t v);
    rst           = v.rst;
    bus.we        = v.we;   bus.waddr  = v.wa;   bus.wdata     = v.wd;
    bus.ex_wreg   = v.exw;  bus.ex_wd  = v.exd;  bus.ex_wdata  = v.exv;
    bus.mem_wreg  = v.memw; bus.mem_wd = v.memd; bus.mem_wdata = v.memv;
    bus.re1       = v.re1;  bus.raddr1 = v.ra1;
    bus.re2       = v.re2;  bus.raddr2 = v.ra2;
  endtask

  task automatic check_out();
    exp_t e;
    if (sb.size() == 0) begin
      failures++;
      $display("FAIL scoreboard_empty: no expected entry available");
      return;
    end
    e = sb.pop_front();
    checks++;
    if (bus.rdata1 !== e.r1) begin
      failures++;
      $display("FAIL %s.rdata1: got %h expected %h", e.name, bus.rdata1, e.r1);
    end
    checks++;
    if (bus.rdata2 !== e.r2) begin
      failures++;
      $display("FAIL %s.rdata2: got %h expected %h", e.name, bus.rdata2, e.r2);
    end
    checks++;
    if (bus.wr_count !== e.cnt) begin
      failures++;
      $display("FAIL %s.wr_count: got %h expected %h", e.name, bus.wr_count, e.cnt);
    end
  endtask

  // Drive one vector, queue its expectation, sample 1ns later, then optionally clock it in.
  task automatic run_vec(input vec_t v, input string nm);
    exp_t e;
    drive(v);
    e.name = nm; e.r1 = v.e1; e.r2 = v.e2; e.cnt = v.ecnt;
    sb.push_back(e);
    #1;
    check_out();
    if (v.tick) begin
      @(posedge clk);
      #2;
    end
  endtask

  function automatic vec_t idle_vec();
    vec_t v;
    v = '{1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
          1'b0, 5'd0, 1'b0, 5'd0, 32'h0, 32'h0, 16'h0};
    return v;
  endfunction

  initial begin
    vec_t v;
    //            tick rst  we   wa     wd             exw  exd    exv        memw memd   memv       re1  ra1    re2  ra2    e1             e2             cnt
    vecs.push_back('{1'b1,1'b0,1'b1,5'd5, 32'h1234_5678,1'b0,5'd0, 32'h0,     1'b0,5'd0, 32'h0,     1'b1,5'd5, 1'b0,5'd0, 32'h1234_5678,32'h0,         16'd0});
    vecs.push_back('{1'b1,1'b0,1'b0,5'd0, 32'h0,        1'b0,5'd0, 32'h0,     1'b0,5'd0, 32'h0,     1'b1,5'd5, 1'b1,5'd5, 32'h1234_5678,32'h1234_5678,16'd1});
    vecs.push_back('{1'b1,1'b1,1'b1,5'd6, 32'h55,       1'b1,5'd5, 32'h99,    1'b1,5'd5, 32'h77,    1'b1,5'd5, 1'b1,5'd6, 32'h0,        32'h0,         16'd1});
    vecs.push_back('{1'b1,1'b0,1'b0,5'd0, 32'h0,        1'b0,5'd0, 32'h0,     1'b0,5'd0, 32'h0,     1'b1,5'd5, 1'b1,5'd6, 32'h0,        32'h0,         16'd0});
    vecs.push_back('{1'b1,1'b0,1'b1,5'd3, 32'hDEAD_BEEF,1'b0,5'd0, 32'h0,     1'b0,5'd0, 32'h0,     1'b1,5'd4, 1'b0,5'd3, 32'h0,        32'h0,         16'd0});
    vecs.push_back('{1'b1,1'b0,1'b0,5'd0, 32'h0,        1'b0,5'd0, 32'h0,     1'b0,5'd0, 32'h0,     1'b1,5'd3, 1'b1,5'd3, 32'hDEAD_BEEF,32'hDEAD_BEEF,16'd1});
    vecs.push_back('{1'b1,1'b0,1'b0,5'd0, 32'h0,        1'b0,5'd0, 32'h0,     1'b0,5'd0, 32'h0,     1'b0,5'd3, 1'b1,5'd3, 32'h0,        32'hDEAD_BEEF,16'd1});
    vecs.push_back('{1'b1,1'b0,1'b1,5'd0, 32'hFFFF_FFFF,1'b1,5'd0, 32'h7,     1'b1,5'd0, 32'h8,     1'b1,5'd0, 1'b1,5'd0, 32'h0,        32'h0,         16'd1});
    vecs.push_back('{1'b1,1'b0,1'b0,5'd0, 32'h0,        1'b0,5'd0, 32'h0,     1'b0,5'd0, 32'h0,     1'b1,5'd0, 1'b1,5'd0, 32'h0,        32'h0,         16'd1});
    vecs.push_back('{1'b1,1'b0,1'b1,5'd8, 32'h1,        1'b0,5'd0, 32'h0,     1'b0,5'd0, 32'h0,     1'b1,5'd8, 1'b0,5'd0, 32'h1,        32'h0,         16'd1});
    vecs.push_back('{1'b0,1'b0,1'b1,5'd8, 32'h2,        1'b1,5'd8, 32'h4,     1'b1,5'd8, 32'h3,     1'b1,5'd8, 1'b1,5'd8, 32'h4,        32'h4,         16'd2});
    vecs.push_back('{1'b0,1'b0,1'b1,5'd8, 32'h2,        1'b0,5'd0, 32'h0,     1'b1,5'd8, 32'h3,     1'b1,5'd8, 1'b1,5'd8, 32'h3,        32'h3,         16'd2});
    vecs.push_back('{1'b1,1'b0,1'b1,5'd8, 32'h2,        1'b0,5'd0, 32'h0,     1'b0,5'd0, 32'h0,     1'b1,5'd8, 1'b1,5'd8, 32'h2,        32'h2,         16'd2});
    vecs.push_back('{1'b1,1'b0,1'b0,5'd0, 32'h0,        1'b0,5'd0, 32'h0,     1'b0,5'd0, 32'h0,     1'b1,5'd8, 1'b1,5'd8, 32'h2,        32'h2,         16'd3});
    vecs.push_back('{1'b1,1'b0,1'b0,5'd0, 32'h0,        1'b1,5'd9, 32'hA,     1'b1,5'd10,32'hB,     1'b1,5'd9, 1'b1,5'd10,32'hA,        32'hB,         16'd3});
    vecs.push_back('{1'b1,1'b0,1'b0,5'd0, 32'h0,        1'b1,5'd9, 32'hA,     1'b1,5'd10,32'hB,     1'b1,5'd9, 1'b1,5'd9, 32'hA,        32'hA,         16'd3});
    vecs.push_back('{1'b1,1'b0,1'b0,5'd0, 32'h0,        1'b0,5'd0, 32'h0,     1'b0,5'd0, 32'h0,     1'b1,5'd9, 1'b1,5'd10,32'h0,        32'h0,         16'd3});
    vecs.push_back('{1'b1,1'b0,1'b1,5'd11,32'h44,       1'b0,5'd0, 32'h0,     1'b1,5'd11,32'h33,    1'b1,5'd11,1'b1,5'd3, 32'h33,       32'hDEAD_BEEF,16'd3});
    vecs.push_back('{1'b1,1'b0,1'b0,5'd0, 32'h0,        1'b0,5'd0, 32'h0,     1'b0,5'd0, 32'h0,     1'b1,5'd11,1'b1,5'd12,32'h44,       32'h0,         16'd4});

    v = idle_vec();
    v.rst = 1'b1;
    drive(v);
    repeat (2) @(posedge clk);
    #2;

    for (int i = 0; i < vecs.size(); i++) begin
      run_vec(vecs[i], $sformatf("vec%0d", i));
    end

    // Counter wrap: clear, commit 65535 writes to r1, then one more.
    v = idle_vec();
    v.rst = 1'b1;
    drive(v);
    @(posedge clk);
    #2;
    for (int i = 1; i <= 65535; i++) begin
      v = idle_vec();
      v.we = 1'b1; v.wa = 5'd1; v.wd = 32'(i);
      drive(v);
      @(posedge clk);
      #2;
    end
    v = idle_vec();
    v.re1 = 1'b1; v.ra1 = 5'd1; v.e1 = 32'h0000_FFFF; v.ecnt = 16'hFFFF;
    run_vec(v, "wrap_pre");
    v = idle_vec();
    v.we = 1'b1; v.wa = 5'd1; v.wd = 32'hCAFE_F00D;
    v.re1 = 1'b1; v.ra1 = 5'd1; v.e1 = 32'hCAFE_F00D; v.ecnt = 16'hFFFF;
    run_vec(v, "wrap_last");
    v = idle_vec();
    v.re1 = 1'b1; v.ra1 = 5'd1; v.re2 = 1'b1; v.ra2 = 5'd1;
    v.e1 = 32'hCAFE_F00D; v.e2 = 32'hCAFE_F00D; v.ecnt = 16'h0000;
    run_vec(v, "wrap_post");

    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_leftover: got %0d entries expected 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
